// File: rtl/load_store_unit.sv
// load_store_unit: data-port initiator with a posted in-order store buffer and
// store-to-load forwarding; load responses are registered with latency 1.
module load_store_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int SB_DEPTH = 2
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] d_addr,
  output logic              rw,
  output logic [DATA_W-1:0] dw_data,
  input  logic [DATA_W-1:0] dr
);
  localparam int PW = SB_DEPTH > 1 ? $clog2(SB_DEPTH) : 1;
  localparam int CW = $clog2(SB_DEPTH + 1);

  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]     count_q, count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, fwd_data;
  logic              full, ld, st, drain;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == SB_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full      = int'(count_q) == SB_DEPTH;
  assign req_ready = !full && (req_we || !rsp_valid_q || rsp_ready);
  assign st        = req_valid && req_ready && req_we;
  assign ld        = req_valid && req_ready && !req_we;
  // A load can only take the port when the buffer is not full, so it never collides with a forced drain.
  assign drain     = full || (!ld && count_q != '0);
  assign rw        = drain;
  assign d_addr    = drain ? sb_addr_q[head_q] : ld ? req_addr : '0;
  assign dw_data   = drain ? sb_data_q[head_q] : '0;
  assign sb_empty  = count_q == '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Walk oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    fwd_data = dr;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = PW'((int'(head_q) + i) % SB_DEPTH);
      if (i < int'(count_q) && sb_addr_q[idx] == req_addr) fwd_data = sb_data_q[idx];
    end
  end

  always_comb begin
    head_d      = drain ? inc(head_q) : head_q;
    tail_d      = st ? inc(tail_q) : tail_q;
    count_d     = count_q + CW'(st) - CW'(drain);
    rsp_valid_d = ld ? 1'b1 : rsp_ready ? 1'b0 : rsp_valid_q;
    rsp_data_d  = ld ? fwd_data : rsp_data_q;
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (st) begin
      sb_addr_q[tail_q] <= req_addr;
      sb_data_q[tail_q] <= req_wdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for stall, reset and full-buffer cases.
module tb_load_store_unit;
  logic        mem_clk = 1'b0, reset = 1'b0, init = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, sb_empty, rw;
  logic [15:0] rsp_data, dw_data, dr;
  logic [7:0]  d_addr;
  logic [15:0] d_mem [256];
  logic [15:0] wlog [$];

  logic        f_req_valid = 1'b0, f_req_we = 1'b0, f_rsp_ready = 1'b1;
  logic [7:0]  f_req_addr = '0;
  logic [15:0] f_req_wdata = '0, f_dr = '0;
  logic        f_req_ready, f_rsp_valid, f_sb_empty, f_rw;
  logic [15:0] f_rsp_data, f_dw_data;
  logic [7:0]  f_d_addr;

  int total = 0, bad = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t v [11];

  load_store_unit #(.ADDR_W(8), .DATA_W(16), .SB_DEPTH(2)) dut (
    .mem_clk(mem_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .sb_empty(sb_empty), .d_addr(d_addr),
    .rw(rw), .dw_data(dw_data), .dr(dr)
  );

  load_store_unit #(.ADDR_W(8), .DATA_W(16), .SB_DEPTH(1)) dut1 (
    .mem_clk(mem_clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_we(f_req_we), .req_addr(f_req_addr), .req_wdata(f_req_wdata), .rsp_valid(f_rsp_valid),
    .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .sb_empty(f_sb_empty), .d_addr(f_d_addr),
    .rw(f_rw), .dw_data(f_dw_data), .dr(f_dr)
  );

  always #5 mem_clk = ~mem_clk;

  function automatic logic [15:0] pat(input int i);
    return (i == 5) ? 16'h1234 : (16'hC000 | 16'(i));
  endfunction

  assign dr = d_mem[d_addr];

  always @(posedge mem_clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) d_mem[i] <= pat(i);
    end else if (rw) begin
      d_mem[d_addr] <= dw_data;
      if (d_addr == 8'h20) wlog.push_back(dw_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp);
    logic got;
    got = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      got = req_ready;
      if (got && !we) begin
        chk("ld_rw", 32'(rw), 32'd0);
        chk("ld_addr", 32'(d_addr), 32'(a));
      end
      tick();
    end
    chk("accept", 32'(got), 32'd1);
    req_valid = 1'b0;
    if (!we) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_data", 32'(rsp_data), 32'(exp));
    end
  endtask

  initial begin
    v[0]  = '{1'b0, 8'h05, 16'h0000, 16'h1234};
    v[1]  = '{1'b1, 8'h10, 16'hBEEF, 16'h0000};
    v[2]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF};
    v[3]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF};
    v[4]  = '{1'b1, 8'h20, 16'h0001, 16'h0000};
    v[5]  = '{1'b1, 8'h20, 16'h0002, 16'h0000};
    v[6]  = '{1'b0, 8'h20, 16'h0000, 16'h0002};
    v[7]  = '{1'b0, 8'h07, 16'h0000, 16'hC007};
    v[8]  = '{1'b1, 8'h07, 16'h1111, 16'h0000};
    v[9]  = '{1'b0, 8'h07, 16'h0000, 16'h1111};
    v[10] = '{1'b0, 8'h20, 16'h0000, 16'h0002};

    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_rw", 32'(rw), 32'd0);
    init  = 1'b0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) do_req(v[i].we, v[i].addr, v[i].wdata, v[i].exp);
    repeat (3) tick();
    chk("drained_empty", 32'(sb_empty), 32'd1);
    chk("mem_10", 32'(d_mem[8'h10]), 32'hBEEF);
    chk("mem_20", 32'(d_mem[8'h20]), 32'h0002);
    chk("mem_07", 32'(d_mem[8'h07]), 32'h1111);
    chk("wlog_n", 32'(wlog.size()), 32'd2);
    chk("wlog_0", 32'(wlog[0]), 32'h0001);
    chk("wlog_1", 32'(wlog[1]), 32'h0002);

    rsp_ready = 1'b0;
    do_req(1'b0, 8'h05, 16'h0, 16'h1234);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'h1234);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_data", 32'(rsp_data), 32'hBEEF);
    tick();
    chk("rsp_drop", 32'(rsp_valid), 32'd0);

    do_req(1'b1, 8'h30, 16'hAAAA, 16'h0);
    chk("pre_rst_rw", 32'(rw), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rw", 32'(rw), 32'd0);
    chk("mid_rst_empty", 32'(sb_empty), 32'd1);
    tick();
    reset = 1'b1;
    chk("mem_30_kept", 32'(d_mem[8'h30]), 32'hC030);
    tick();
    do_req(1'b0, 8'h30, 16'h0, 16'hC030);

    f_req_valid = 1'b1;
    f_req_we    = 1'b1;
    f_req_addr  = 8'h40;
    f_req_wdata = 16'h4444;
    #1;
    chk("f_ready0", 32'(f_req_ready), 32'd1);
    tick();
    f_req_addr  = 8'h41;
    f_req_wdata = 16'h5555;
    #1;
    chk("f_full_ready", 32'(f_req_ready), 32'd0);
    chk("f_full_rw", 32'(f_rw), 32'd1);
    chk("f_full_addr", 32'(f_d_addr), 32'h40);
    chk("f_full_data", 32'(f_dw_data), 32'h4444);
    tick();
    #1;
    chk("f_retry_ready", 32'(f_req_ready), 32'd1);
    chk("f_retry_rw", 32'(f_rw), 32'd0);
    tick();
    f_req_valid = 1'b0;
    #1;
    chk("f_drain2_rw", 32'(f_rw), 32'd1);
    chk("f_drain2_addr", 32'(f_d_addr), 32'h41);
    tick();
    chk("f_empty", 32'(f_sb_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
